// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared constants and types for the result-mux arbiter.
//   N_REQ   - number of requesters sharing the 16-bit result mux
//   SEL_W   - width of the binary mux select
//   state_t - arbiter FSM states
//   onehot  - binary index to one-hot grant vector
package mux_arbiter_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StOwn  = 2'b01,
      StTurn = 2'b10
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: requester-side bundle of the result-mux arbiter.
//   req     - per-requester request
//   done    - per-requester release strobe
//   grant   - one-hot grant (all zero when unowned)
//   sel     - binary mux control, index of current or last owner
//   busy    - grant is nonzero
//   timeout - one-cycle pulse when a grant is revoked on hold expiry
// master: the requesters; slave: the arbiter.
interface mux_arbiter_if;
   import mux_arbiter_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] grant;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, sel, busy, timeout
   );

   modport slave (
      input  req, done,
      output grant, sel, busy, timeout
   );

endinterface

// File: rtl/mux_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick.
//   req - request vector
//   ptr - index where the upward scan starts (wraps modulo N_REQ)
//   hit - at least one request is set
//   idx - first set request at or above ptr, modulo N_REQ
module rr_picker
   import mux_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             hit,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // Scan from the far end back toward ptr so the nearest request wins.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner arbiter for the shared 8:1 16-bit result mux.
//   clk   - sole clock, rising edge
//   reset - synchronous, active high, overrides everything
//   bus   - mux_arbiter_if.slave (req/done in, grant/sel/busy/timeout out)
// Parameter MAX_HOLD (2..255) caps how many consecutive cycles one owner may hold the grant.
// Each grant is followed by one turnaround cycle and one idle cycle before the next.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input logic          clk,
   input logic          reset,
   mux_arbiter_if.slave bus
);

   localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [7:0]       hold_q, hold_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic             hit;
   logic [SEL_W-1:0] idx;
   logic             owner_done, owner_req, at_max;

   rr_picker u_picker (
      .req (bus.req),
      .ptr (ptr_q),
      .hit (hit),
      .idx (idx)
   );

   // Only the current owner's strobes matter; others are ignored while owned.
   assign owner_done = bus.done[sel_q];
   assign owner_req  = bus.req[sel_q];
   assign at_max     = (hold_q == HoldMax);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hit) begin
               grant_d = onehot(idx);
               sel_d   = idx;
               busy_d  = 1'b1;
               hold_d  = 8'd1;
               state_d = StOwn;
            end
         end
         StOwn: begin
            if (owner_done || !owner_req || at_max) begin
               grant_d   = '0;
               busy_d    = 1'b0;
               ptr_d     = sel_q + 1'b1;
               hold_d    = '0;
               state_d   = StTurn;
               // A voluntary release on the last allowed cycle is not a timeout.
               timeout_d = at_max && !owner_done && owner_req;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         StTurn: begin
            // Bus turnaround; requests are deliberately not sampled here.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against an owner/turnaround model of the arbiter.
module tb_mux_arbiter;

   localparam int unsigned MaxHold = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   bit   check_en;

   mux_arbiter_if tif ();

   mux_arbiter #(
      .MAX_HOLD (MaxHold)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the bus, for how long, and whether we are in turnaround.
   int m_owner;    // -1 when nobody owns the mux
   int m_held;     // cycles the current owner has held the grant
   int m_ptr;
   int m_last;     // sel value
   bit m_turn;
   bit m_to;

   initial begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_turn = 0; m_to = 0;
   end

   always @(posedge clk) begin
      m_to = 0;
      if (reset) begin
         m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_turn = 0;
      end else if (m_turn) begin
         m_turn = 0;
      end else if (m_owner >= 0) begin
         if (tif.done[m_owner] || !tif.req[m_owner] || m_held == int'(MaxHold)) begin
            m_to    = !tif.done[m_owner] && tif.req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_held  = 0;
            m_turn  = 1;
         end else begin
            m_held++;
         end
      end else if (tif.req != 8'h00) begin
         for (int k = 0; k < 8; k++) begin
            if (m_owner < 0 && tif.req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
         end
         m_last = m_owner;
         m_held = 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("grant", 32'(tif.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("sel", 32'(tif.sel), 32'(m_last));
         check("busy", 32'(tif.busy), 32'(m_owner >= 0));
         check("timeout", 32'(tif.timeout), 32'(m_to));
      end
   end

   task automatic at_post();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      check_en = 0;
      reset    = 1'b1;
      tif.req  = 8'h00;
      tif.done = 8'h00;
      repeat (3) @(negedge clk);
      check_en = 1;
      check("rst_grant", 32'(tif.grant), 32'h0);
      check("rst_sel", 32'(tif.sel), 32'h0);
      check("rst_busy", 32'(tif.busy), 32'h0);
      check("rst_timeout", 32'(tif.timeout), 32'h0);

      // Single requester 2, released by done.
      reset   = 1'b0;
      tif.req = 8'h04;
      at_post();
      check("r2_grant", 32'(tif.grant), 32'h04);
      check("r2_sel", 32'(tif.sel), 32'd2);
      @(negedge clk) tif.done = 8'h04;
      at_post();
      check("r2_release", 32'(tif.grant), 32'h0);
      check("r2_sel_kept", 32'(tif.sel), 32'd2);
      @(negedge clk);
      tif.done = 8'h00;
      tif.req  = 8'h0C;
      at_post();
      check("idle_gap", 32'(tif.grant), 32'h0);
      at_post();
      check("ptr3_grant", 32'(tif.grant), 32'h08);

      // Owner 3 runs into the hold limit.
      repeat (3) at_post();
      check("hold4_grant", 32'(tif.grant), 32'h08);
      at_post();
      check("to_grant", 32'(tif.grant), 32'h0);
      check("to_pulse", 32'(tif.timeout), 32'h1);
      at_post();
      check("to_cleared", 32'(tif.timeout), 32'h0);
      at_post();
      check("wrap_grant", 32'(tif.grant), 32'h04);

      // done on the last allowed cycle: normal release.
      repeat (3) at_post();
      @(negedge clk) tif.done = 8'h04;
      at_post();
      check("done_at_max_grant", 32'(tif.grant), 32'h0);
      check("done_at_max_to", 32'(tif.timeout), 32'h0);

      // Reset while owner 4 holds the grant.
      @(negedge clk);
      tif.done = 8'h00;
      tif.req  = 8'h10;
      at_post();
      at_post();
      check("own4_grant", 32'(tif.grant), 32'h10);
      @(negedge clk) reset = 1'b1;
      at_post();
      check("midrst_grant", 32'(tif.grant), 32'h0);
      check("midrst_sel", 32'(tif.sel), 32'h0);
      check("midrst_busy", 32'(tif.busy), 32'h0);
      check("midrst_to", 32'(tif.timeout), 32'h0);
      @(negedge clk);
      reset   = 1'b0;
      tif.req = 8'hFF;
      at_post();
      check("post_rst_ptr0", 32'(tif.grant), 32'h01);

      // Non-owner done bits ignored while requester 0 holds.
      @(negedge clk) tif.done = 8'hFE;
      at_post();
      check("nonowner_done", 32'(tif.grant), 32'h01);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) != 0) tif.req = tif.req;
         else tif.req = 8'($urandom);
         tif.done = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one grant may be held (legal range 2..255).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  8  per-requester request for the shared 16-bit 8:1 result mux; bit i = requester i.
REQ-005 Port: done  input  8  per-requester release strobe; only done[sel] is honoured while granted.
REQ-006 Port: grant  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 Port: sel  output  3  registered mux control, binary index of current or last owner.
REQ-008 Port: busy  output  1  registered; high when grant is nonzero.
REQ-009 Port: timeout  output  1  registered one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 The block SHALL implement states IDLE, OWN and TURN, held in a registered state variable.
REQ-011 In IDLE with req nonzero, the block SHALL pick the first set req bit scanning upward from ptr modulo 8, then at the next edge set grant to that one-hot bit, set sel to its index, and enter OWN.
REQ-012 Grant latency SHALL be exactly one cycle from req sampled high in IDLE to grant high.
REQ-013 In IDLE with req zero, the block SHALL stay in IDLE with grant=0 and sel unchanged.
REQ-014 In OWN, a hold counter SHALL start at 1 on the grant cycle and increment once per cycle the grant is held.
REQ-015 In OWN, release SHALL occur on the first cycle in which done[sel]=1, or req[sel]=0, or the hold counter equals MAX_HOLD.
REQ-016 On release, at the next edge: grant=0, busy=0, ptr=(sel+1) mod 8, state=TURN, sel unchanged.
REQ-017 If release is caused only by the hold counter reaching MAX_HOLD (done[sel]=0 and req[sel]=1), timeout SHALL pulse high for the one cycle coinciding with TURN.
REQ-018 When done[sel] or a dropped req[sel] coincides with the hold counter reaching MAX_HOLD, the release SHALL be treated as normal and timeout SHALL stay low.
REQ-019 TURN SHALL last exactly one cycle with grant=0 (bus turnaround), then the block SHALL enter IDLE; req is not evaluated during TURN.
REQ-020 Minimum spacing between two grants SHALL therefore be one TURN cycle plus one IDLE cycle.
REQ-021 done bits of non-owners and req changes of non-owners during OWN SHALL have no effect.
REQ-022 ptr wrap: index 7 released SHALL set ptr to 0.
REQ-023 grant SHALL never have more than one bit set, and sel SHALL equal the index of the set bit whenever busy=1.

Reset
REQ-024 While reset=1 at a rising edge: state=IDLE, grant=0, sel=0, busy=0, timeout=0, ptr=0, hold counter=0.
REQ-025 Reset asserted mid-OWN SHALL revoke the grant at that edge without a timeout pulse or TURN cycle.
REQ-026 reset SHALL have priority over all other inputs.

Structure
REQ-027 N_REQ=8, SEL_W=3 and the IDLE/OWN/TURN state encodings SHALL live in a shared package/include file used by the processor top level.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module rr_picker (inputs req, ptr; outputs hit, idx).
REQ-029 sel SHALL drive the existing 8:1 16-bit mux control directly, with no added logic.

Verification
REQ-030 Reset, then req=8'b0000_0100 held -> grant=8'h04, sel=2 one cycle later; done[2] pulse -> grant=0 next edge, TURN, ptr=3.
REQ-031 req=8'hFF, every owner asserts done on its 2nd grant cycle -> grant order 0,1,2,...,7,0 with sel matching and one TURN plus one IDLE cycle between grants.
REQ-032 MAX_HOLD=4, req=8'h01 held, done=0 -> grant held exactly 4 cycles, then timeout=1 for one cycle, then re-grant to 0 after IDLE.
REQ-033 MAX_HOLD=4, done[0] asserted on the 4th held cycle -> release with timeout=0.
REQ-034 Owner 5 granted, req=8'hFF and done=8'hDF -> grant stays 8'h20; then req[5] drops -> release and ptr=6.
REQ-035 reset pulsed while grant=8'h10 -> grant=0, sel=0, busy=0, timeout=0 next edge; next arbitration starts from ptr=0.
